// File: rtl/awgn_pkg.sv
`default_nettype none
// ============================================================================
// Module      : awgn_pkg
// Description : Shared constants and types for the AWGN generator datapath
//               (Sqrt stage and Box-Muller multiplier).
//               Formats: f unsigned Q6.11, g signed Q1.15, x signed Q5.11.
// Revision    : 1.0 - initial release
// ============================================================================
package awgn_pkg;

  // Sqrt output f
  localparam int AWGN_F_W    = 17;
  localparam int AWGN_F_INT  = 6;
  localparam int AWGN_F_FRAC = AWGN_F_W - AWGN_F_INT;

  // cos/sin samples g0/g1 (Q1.15)
  localparam int AWGN_G_W    = 16;

  // Noise sample x (Q5.11)
  localparam int AWGN_X_W    = 16;

  // Going from a Q.26 product to Q.11 drops G_W-1 fraction bits.
  localparam int AWGN_RND_SHIFT = AWGN_G_W - 1;

  // Round-half-up constant for a right shift by 'shift' bits.
  function automatic int rnd_const(input int shift);
    return 1 << (shift - 1);
  endfunction

  localparam int AWGN_RND = rnd_const(AWGN_RND_SHIFT);

  // Output channel select: which product of the pair is presented.
  typedef enum logic {
    SEL_X0 = 1'b0,
    SEL_X1 = 1'b1
  } sel_e;

endpackage : awgn_pkg
`default_nettype wire

// File: rtl/awgn_bm_mult_if.sv
`default_nettype none
// ============================================================================
// Module      : awgn_bm_mult_if
// Description : Stream interface of the Box-Muller multiplier.
//               Input side : f_in, g0_in, g1_in, in_valid / in_ready
//               Output side: out_data, out_ch, out_valid / out_ready
//               master - upstream producer + downstream consumer (bench/top)
//               slave  - the multiplier block itself
// Revision    : 1.0 - initial release
// ============================================================================
interface awgn_bm_mult_if
  import awgn_pkg::*;
#(
  parameter int F_W = AWGN_F_W,
  parameter int G_W = AWGN_G_W,
  parameter int X_W = AWGN_X_W
) ();

  logic        [F_W-1:0] f_in;
  logic signed [G_W-1:0] g0_in;
  logic signed [G_W-1:0] g1_in;
  logic                  in_valid;
  logic                  in_ready;
  logic signed [X_W-1:0] out_data;
  logic                  out_ch;
  logic                  out_valid;
  logic                  out_ready;

  modport master (
    output f_in, g0_in, g1_in, in_valid, out_ready,
    input  in_ready, out_data, out_ch, out_valid
  );

  modport slave (
    input  f_in, g0_in, g1_in, in_valid, out_ready,
    output in_ready, out_data, out_ch, out_valid
  );

endinterface : awgn_bm_mult_if
`default_nettype wire

// File: rtl/awgn_round_sat.sv
`default_nettype none
// ============================================================================
// Module      : awgn_round_sat
// Description : Combinational round-half-up and saturate of one signed
//               product down to an X_W-bit signed sample.
// Ports       : i_p  - signed product, P_W bits
//               o_x  - rounded, saturated result, X_W bits
// Revision    : 1.0 - initial release
// ============================================================================
module awgn_round_sat
  import awgn_pkg::*;
#(
  parameter int P_W   = AWGN_F_W + AWGN_G_W,
  parameter int X_W   = AWGN_X_W,
  parameter int SHIFT = AWGN_RND_SHIFT,
  parameter int RND   = AWGN_RND
) (
  input  wire signed [P_W-1:0] i_p,
  output logic signed [X_W-1:0] o_x
);

  localparam logic signed [P_W-1:0] c_rnd = P_W'(RND);
  localparam logic signed [X_W-1:0] c_max = {1'b0, {(X_W-1){1'b1}}};
  localparam logic signed [X_W-1:0] c_min = {1'b1, {(X_W-1){1'b0}}};

  logic signed [P_W-1:0] w_sum;
  logic signed [P_W-1:0] w_sh;
  logic                  w_ovf;

  // The largest |product| stays well clear of the P_W limit, so adding the
  // rounding constant cannot wrap.
  assign w_sum = i_p + c_rnd;
  assign w_sh  = w_sum >>> SHIFT;

  // Result fits only if every bit above the X_W-bit field repeats its sign.
  assign w_ovf = !((&w_sh[P_W-1:X_W-1]) || !(|w_sh[P_W-1:X_W-1]));

  always_comb begin
    o_x = w_sh[X_W-1:0];
    if (w_ovf) begin
      o_x = w_sh[P_W-1] ? c_min : c_max;
    end
  end

endmodule : awgn_round_sat
`default_nettype wire

// File: rtl/awgn_bm_mult.sv
`default_nettype none
// ============================================================================
// Module      : awgn_bm_mult
// Description : Box-Muller multiplier. Forms x0 = f*g0 and x1 = f*g1 in a
//               3-stage lockstep pipeline (input regs, products, rounded
//               pair) and serialises the pair onto one output stream,
//               x0 first (out_ch=0) then x1 (out_ch=1).
// Ports       : clk  - rising-edge clock
//               rst  - asynchronous active-low reset
//               bus  - awgn_bm_mult_if.slave
//                      in : f_in (unsigned), g0_in/g1_in (signed), in_valid
//                      out: in_ready, out_data, out_ch, out_valid
//                      in : out_ready
// Revision    : 1.0 - initial release
// ============================================================================
module awgn_bm_mult
  import awgn_pkg::*;
#(
  parameter int F_W   = AWGN_F_W,
  parameter int F_INT = AWGN_F_INT,
  parameter int G_W   = AWGN_G_W,
  parameter int X_W   = AWGN_X_W
) (
  input wire            clk,
  input wire            rst,
  awgn_bm_mult_if.slave bus
);

  // One extra bit over F_W+G_W is never needed: f is non-negative and
  // |g| <= 2^(G_W-1), so |f*g| < 2^(F_W+G_W-1).
  localparam int c_p_w    = F_W + G_W;
  localparam int c_f_frac = F_W - F_INT;
  localparam int c_p_frac = c_f_frac + (G_W - 1);
  // Output keeps the fraction width of f.
  localparam int c_shift  = c_p_frac - c_f_frac;
  localparam int c_rnd    = rnd_const(c_shift);

  // Pipeline state
  logic                    r_v1, r_v2, r_v3;
  logic        [F_W-1:0]   r_f;
  logic signed [G_W-1:0]   r_g0, r_g1;
  logic signed [c_p_w-1:0] r_p0, r_p1;
  logic signed [X_W-1:0]   r_x0, r_x1;
  sel_e                    r_sel;

  // Combinational
  logic                    w_adv;
  logic                    w_out_fire;
  sel_e                    w_sel_nxt;
  logic signed [c_p_w-1:0] w_f_ext, w_g0_ext, w_g1_ext;
  logic signed [c_p_w-1:0] w_p0, w_p1;
  logic signed [X_W-1:0]   w_x0, w_x1;

  // --------------------------------------------------------------------------
  // Flow control: the whole pipe moves only when S3 is empty or its second
  // sample is leaving, so a pair is never split across two S3 loads.
  // --------------------------------------------------------------------------
  assign w_out_fire   = r_v3 && bus.out_ready;
  assign w_adv        = !r_v3 || (w_out_fire && (r_sel == SEL_X1));
  assign bus.in_ready = w_adv;

  assign bus.out_valid = r_v3;
  assign bus.out_data  = (r_sel == SEL_X1) ? r_x1 : r_x0;
  assign bus.out_ch    = (r_sel == SEL_X1);

  // --------------------------------------------------------------------------
  // Products: f is zero-extended, g sign-extended, both to the product width,
  // so the signed multiply at that width is exact.
  // --------------------------------------------------------------------------
  assign w_f_ext  = {{(c_p_w-F_W){1'b0}}, r_f};
  assign w_g0_ext = {{(c_p_w-G_W){r_g0[G_W-1]}}, r_g0};
  assign w_g1_ext = {{(c_p_w-G_W){r_g1[G_W-1]}}, r_g1};
  assign w_p0     = w_f_ext * w_g0_ext;
  assign w_p1     = w_f_ext * w_g1_ext;

  awgn_round_sat #(
    .P_W   (c_p_w),
    .X_W   (X_W),
    .SHIFT (c_shift),
    .RND   (c_rnd)
  ) u_rs_x0 (
    .i_p (r_p0),
    .o_x (w_x0)
  );

  awgn_round_sat #(
    .P_W   (c_p_w),
    .X_W   (X_W),
    .SHIFT (c_shift),
    .RND   (c_rnd)
  ) u_rs_x1 (
    .i_p (r_p1),
    .o_x (w_x1)
  );

  // --------------------------------------------------------------------------
  // Stage valids: bubbles propagate whenever the pipe advances.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_v1 <= 1'b0;
      r_v2 <= 1'b0;
      r_v3 <= 1'b0;
    end else if (w_adv) begin
      r_v1 <= bus.in_valid;
      r_v2 <= r_v1;
      r_v3 <= r_v2;
    end
  end

  // --------------------------------------------------------------------------
  // Stage data: each register loads only when its stage receives a valid
  // entry, so idle cycles leave the datapath quiet.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_f  <= '0;
      r_g0 <= '0;
      r_g1 <= '0;
      r_p0 <= '0;
      r_p1 <= '0;
      r_x0 <= '0;
      r_x1 <= '0;
    end else if (w_adv) begin
      if (bus.in_valid) begin
        r_f  <= bus.f_in;
        r_g0 <= bus.g0_in;
        r_g1 <= bus.g1_in;
      end
      if (r_v1) begin
        r_p0 <= w_p0;
        r_p1 <= w_p1;
      end
      if (r_v2) begin
        r_x0 <= w_x0;
        r_x1 <= w_x1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Output channel select. Accepting x1 also advances the pipe, so the next
  // pair lands in S3 on the same edge that sel returns to x0.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sel <= SEL_X0;
    end else begin
      r_sel <= w_sel_nxt;
    end
  end

  always_comb begin
    w_sel_nxt = r_sel;
    if (w_out_fire) begin
      case (r_sel)
        SEL_X0:  w_sel_nxt = SEL_X1;
        SEL_X1:  w_sel_nxt = SEL_X0;
        default: w_sel_nxt = SEL_X0;
      endcase
    end
  end

endmodule : awgn_bm_mult
`default_nettype wire

// File: tb/tb_awgn_bm_mult.sv
`default_nettype none
// ============================================================================
// Module      : tb_awgn_bm_mult
// Description : Directed self-checking bench for awgn_bm_mult. Inputs are
//               driven and outputs sampled on the falling clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_awgn_bm_mult;

  logic clk = 1'b0;
  logic rst;

  int n_checks = 0;
  int n_errors = 0;

  // Vector table: 0..3 single-pair cases, 4..13 streaming set.
  logic        [16:0] t_f  [14];
  logic signed [15:0] t_g0 [14];
  logic signed [15:0] t_g1 [14];
  int                 t_x0 [14];
  int                 t_x1 [14];

  always #5 clk = ~clk;

  awgn_bm_mult_if bus ();

  awgn_bm_mult u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic set_vec(input int i, input int f, input int g0, input int g1,
                         input int x0, input int x1);
    t_f[i]  = 17'(f);
    t_g0[i] = 16'(g0);
    t_g1[i] = 16'(g1);
    t_x0[i] = x0;
    t_x1[i] = x1;
  endtask

  // Feed n triples starting at table index 'base' and check the 2n outputs
  // in order. out_ready is low on cycles stall_lo..stall_hi. Called and left
  // on a falling edge with an empty pipe.
  task automatic run_stream(input int base, input int n, input int stall_lo,
                            input int stall_hi, input int exp_stalls,
                            input int exp_last);
    int idx = 0;
    int oidx = 0;
    int cyc = 0;
    int stalls = 0;
    int first_cyc = -1;
    int last_cyc = -1;
    int exp_d;
    while (oidx < 2*n && cyc < 200) begin
      bus.out_ready = !(cyc >= stall_lo && cyc <= stall_hi);
      if (idx < n) begin
        bus.in_valid = 1'b1;
        bus.f_in     = t_f[base+idx];
        bus.g0_in    = t_g0[base+idx];
        bus.g1_in    = t_g1[base+idx];
      end else begin
        bus.in_valid = 1'b0;
      end
      #1;
      if (bus.out_valid) begin
        if (first_cyc < 0) first_cyc = cyc;
        exp_d = oidx[0] ? t_x1[base+oidx/2] : t_x0[base+oidx/2];
        check("out_ch", int'(bus.out_ch), oidx % 2);
        check("out_data", int'($signed(bus.out_data)), exp_d);
        if (!bus.out_ready) begin
          check("stall_in_ready", int'(bus.in_ready), 0);
        end else begin
          oidx++;
          last_cyc = cyc;
        end
      end
      if (bus.in_valid) begin
        if (bus.in_ready) idx++;
        else stalls++;
      end
      @(negedge clk);
      cyc++;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    check("outputs_seen", oidx, 2*n);
    check("first_out_cycle", first_cyc, 3);
    check("last_out_cycle", last_cyc, exp_last);
    check("in_ready_low_cycles", stalls, exp_stalls);
    check("drained", int'(bus.out_valid), 0);
  endtask

  initial begin
    bit found;

    // Expected values hand-computed as floor((f*g + 2^14) / 2^15), clamped.
    set_vec(0,   2048,  32767, -32768,   2048,  -2048);
    set_vec(1, 131071,  32767, -32768,  32767, -32768);
    set_vec(2,      0,  12345,     -5,      0,      0);
    set_vec(3,   3001,  16384, -16384,   1501,  -1500);
    // f = 2048*k (k = 1..10) and g multiples of 16: x = k*g/16 exactly.
    set_vec(4,   2048,    160,   -160,     10,    -10);
    set_vec(5,   4096,    320,    -32,     40,     -4);
    set_vec(6,   6144,   1600,     16,    300,      3);
    set_vec(7,   8192,  -3200,    800,   -800,    200);
    set_vec(8,  10240,  16000, -16000,   5000,  -5000);
    set_vec(9,  12288,  32000,    -48,  12000,    -18);
    set_vec(10, 14336,      0,   4800,      0,   2100);
    set_vec(11, 16384, -32768,  32752, -16384,  16376);
    set_vec(12, 18432,   1024,  -2048,    576,  -1152);
    set_vec(13, 20480,  30000, -30000,  18750, -18750);

    rst           = 1'b0;
    bus.in_valid  = 1'b0;
    bus.f_in      = '0;
    bus.g0_in     = '0;
    bus.g1_in     = '0;
    bus.out_ready = 1'b1;

    #2;
    check("rst_out_valid", int'(bus.out_valid), 0);
    check("rst_out_data", int'($signed(bus.out_data)), 0);
    check("rst_out_ch", int'(bus.out_ch), 0);
    check("rst_in_ready", int'(bus.in_ready), 1);

    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    run_stream(0, 1, -1, -2, 0, 4);     // unity gain, +/- full scale g
    run_stream(1, 1, -1, -2, 0, 4);     // saturation both ways
    run_stream(2, 1, -1, -2, 0, 4);     // f = 0
    run_stream(3, 1, -1, -2, 0, 4);     // round half up on +/- x.5
    run_stream(4, 10, -1, -2, 7, 22);   // back-to-back, one pair per 2 cycles
    run_stream(4, 10, 5, 9, 12, 27);    // consumer stalls 5 cycles, pipe full

    // Reset while x1 of a pair is on the output and more pairs are in flight.
    found         = 1'b0;
    bus.in_valid  = 1'b1;
    bus.f_in      = t_f[4];
    bus.g0_in     = t_g0[4];
    bus.g1_in     = t_g1[4];
    bus.out_ready = 1'b1;
    for (int c = 0; c < 20 && !found; c++) begin
      #1;
      if (bus.out_valid && bus.out_ch) found = 1'b1;
      else @(negedge clk);
    end
    check("x1_reached_before_rst", int'(found), 1);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    #1;
    rst = 1'b0;
    #1;
    check("midrst_out_valid", int'(bus.out_valid), 0);
    check("midrst_out_data", int'($signed(bus.out_data)), 0);
    check("midrst_out_ch", int'(bus.out_ch), 0);
    check("midrst_in_ready", int'(bus.in_ready), 1);
    @(negedge clk);
    rst           = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    run_stream(0, 1, -1, -2, 0, 4);     // only the new triple may emerge

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule : tb_awgn_bm_mult
`default_nettype wire

// File: doc/awgn_bm_mult.md
AWGN_BM_MULT -- requirements
Module: awgn_bm_mult

Interface
REQ-001 SHALL have parameter F_W, 17, width of the unsigned Sqrt output f.
REQ-002 SHALL have parameter F_INT, 6, integer bits of f; fraction bits F_FRAC = F_W-F_INT (11).
REQ-003 SHALL have parameter G_W, 16, width of signed Q1.15 cos/sin samples g0/g1.
REQ-004 SHALL have parameter X_W, 16, width of signed output noise sample, format Q5.11.
REQ-005 SHALL have port clk  in  1  rising-edge clock.
REQ-006 SHALL have port rst  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have port f_in  in  F_W  unsigned sqrt(-2ln u0) from the Sqrt stage.
REQ-008 SHALL have port g0_in  in  G_W  signed cos(2*pi*u1).
REQ-009 SHALL have port g1_in  in  G_W  signed sin(2*pi*u1).
REQ-010 SHALL have port in_valid  in  1  f_in/g0_in/g1_in are valid.
REQ-011 SHALL have port in_ready  out  1  block accepts an input triple this cycle.
REQ-012 SHALL have port out_data  out  X_W  noise sample x0 or x1.
REQ-013 SHALL have port out_ch  out  1  0 = x0 (f*g0), 1 = x1 (f*g1).
REQ-014 SHALL have port out_valid  out  1  out_data valid.
REQ-015 SHALL have port out_ready  in  1  consumer accepts out_data.

Function
REQ-016 SHALL accept a triple on a rising edge where in_valid && in_ready.
REQ-017 SHALL be a 3-stage lockstep pipeline: S1 input regs, S2 two signed products p = f*g (F_W+G_W bits, 26 fraction bits), S3 rounded/saturated pair {x0,x1}, each stage with a valid bit.
REQ-018 SHALL round each product as (p + 2^14) arithmetic-shifted right by 15, then saturate to [-32768, 32767].
REQ-019 SHALL treat f_in as unsigned (zero-extended) and g as two's complement.
REQ-020 SHALL define adv = !v3 || (out_valid && out_ready && sel==1); all stages load only when adv; in_ready = adv.
REQ-021 SHALL drive out_valid = v3, out_data = sel ? x1 : x0, out_ch = sel.
REQ-022 SHALL toggle sel 0->1 on an accepted x0 and 1->0 on an accepted x1; sel holds when not accepted.
REQ-023 SHALL hold out_data/out_ch stable while out_valid && !out_ready.
REQ-024 SHALL give latency: triple accepted at edge k into empty pipe -> out_valid with x0 after edge k+2; x1 one accepted cycle later.
REQ-025 SHALL sustain one pair per 2 cycles with out_ready=1 (in_ready low every other cycle when full).
REQ-026 SHALL propagate in_valid=0 as bubbles (stage valid=0) when adv.
REQ-027 SHALL, on simultaneous x1 acceptance and new input, load S3 from S2 and reset sel to 0 in the same edge.

Reset
REQ-028 SHALL on rst low clear v1,v2,v3, sel to 0 and all data regs to 0 immediately; out_valid=0, out_data=0, out_ch=0, in_ready=1.
REQ-029 SHALL discard any in-flight pair on reset mid-operation; first post-reset output comes only from new inputs.

Structure
REQ-030 SHALL take F_W, F_INT, G_W, X_W defaults and round constant from shared package awgn_pkg used by Sqrt and this block.
REQ-031 SHALL instantiate twice a sub-module awgn_round_sat (combinational round+saturate of one product).

Verification
REQ-032 SHALL check f=2048, g0=32767, g1=-32768 -> x0=2048 (ch0), then x1=-2048 (ch1), x0 after edge k+2.
REQ-033 SHALL check f=131071, g0=32767, g1=-32768 -> x0=32767, x1=-32768 (saturation).
REQ-034 SHALL check f=0, any g -> x0=0, x1=0.
REQ-035 SHALL check 10 back-to-back triples, out_ready=1 -> 20 outputs alternating ch 0/1, in order, in_ready toggling.
REQ-036 SHALL check out_ready=0 for 5 cycles with pipe full -> in_ready=0, out_data stable, no loss/duplication.
REQ-037 SHALL check rst low while out_valid=1 with sel=1 -> out_valid=0 immediately; next output is x0 of a new triple.
